collision_detector: RTL and testbench

Consumer of the per-pixel sprite flags produced by the alien and missile blocks. It watches `is_alien` and `is_missile` during raster scan and captures the first pixel where both are set in each frame. At the next frame boundary it reports that hit to the game controller through a valid/ack handshake, and it keeps a saturating hit counter for the score logic.

---
 rtl/game_pkg.sv | 13 +
 rtl/frame_edge_detect.sv | 22 ++
 rtl/collision_detector.sv | 131 +++++++++++++
 tb/tb_collision_detector.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants, coordinate type and FSM state enums used by the sprite
// and collision blocks.
package game_pkg;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;

  typedef logic [9:0] coord_t;

  typedef enum logic {SCAN, CAPTURED} cap_state_t;
  typedef enum logic {IDLE, VALID}    rpt_state_t;

endpackage

// File: rtl/frame_edge_detect.sv
// Turns the vsync-derived frame_clk level into a registered one-cycle pulse
// on each rising edge, for use by any block that works per frame.
module frame_edge_detect (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic frame_edge
);

  logic frame_clk_delayed;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_delayed <= 1'b0;
      frame_edge        <= 1'b0;
    end else begin
      frame_clk_delayed <= frame_clk;
      frame_edge        <= frame_clk && !frame_clk_delayed;
    end
  end

endmodule

// File: rtl/collision_detector.sv
// Captures the first alien/missile overlap of each frame and reports it at the
// next frame boundary over a valid/ack handshake. Optional: COLLISION_OVERRUN_EN.
module collision_detector
  import game_pkg::*;
#(
  parameter logic [9:0]  SCREEN_W = game_pkg::SCREEN_W,
  parameter logic [9:0]  SCREEN_H = game_pkg::SCREEN_H,
  parameter int unsigned COUNT_W  = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  coord_t             DrawX,
  input  coord_t             DrawY,
  input  logic               is_alien,
  input  logic               is_missile,
  input  logic               hit_ack,
  output logic               hit_valid,
  output coord_t             hit_x,
  output coord_t             hit_y,
  output logic [COUNT_W-1:0] hit_count
`ifdef COLLISION_OVERRUN_EN
  ,
  output logic               overrun
`endif
);

  logic       frame_edge;
  logic       overlap;
  logic       pending;
  cap_state_t cap_state, cap_state_n;
  rpt_state_t rpt_state, rpt_state_n;
  coord_t     cap_x, cap_y, cap_x_n, cap_y_n;
  coord_t     hit_x_n, hit_y_n;
  logic [COUNT_W-1:0] hit_count_n;
`ifdef COLLISION_OVERRUN_EN
  logic       overrun_n;
`endif

  frame_edge_detect u_frame_edge (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .frame_edge (frame_edge)
  );

  assign overlap   = is_alien && is_missile && (DrawX < SCREEN_W) && (DrawY < SCREEN_H);
  assign pending   = frame_edge && (cap_state == CAPTURED);
  assign hit_valid = (rpt_state == VALID);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cap_state <= SCAN;
      rpt_state <= IDLE;
      cap_x     <= '0;
      cap_y     <= '0;
      hit_x     <= '0;
      hit_y     <= '0;
      hit_count <= '0;
`ifdef COLLISION_OVERRUN_EN
      overrun   <= 1'b0;
`endif
    end else begin
      cap_state <= cap_state_n;
      rpt_state <= rpt_state_n;
      cap_x     <= cap_x_n;
      cap_y     <= cap_y_n;
      hit_x     <= hit_x_n;
      hit_y     <= hit_y_n;
      hit_count <= hit_count_n;
`ifdef COLLISION_OVERRUN_EN
      overrun   <= overrun_n;
`endif
    end
  end

  // Frame edge hands the old capture to the report side while this cycle's
  // overlap, if any, already belongs to the new frame.
  always_comb begin
    cap_state_n = cap_state;
    cap_x_n     = cap_x;
    cap_y_n     = cap_y;
    if (frame_edge) begin
      cap_state_n = overlap ? CAPTURED : SCAN;
      if (overlap) begin
        cap_x_n = DrawX;
        cap_y_n = DrawY;
      end
    end else if (cap_state == SCAN && overlap) begin
      cap_state_n = CAPTURED;
      cap_x_n     = DrawX;
      cap_y_n     = DrawY;
    end
  end

  always_comb begin
    rpt_state_n = rpt_state;
    hit_x_n     = hit_x;
    hit_y_n     = hit_y;
    hit_count_n = hit_count;
`ifdef COLLISION_OVERRUN_EN
    overrun_n   = overrun;
`endif
    case (rpt_state)
      IDLE: begin
        if (pending) begin
          rpt_state_n = VALID;
          hit_x_n     = cap_x;
          hit_y_n     = cap_y;
        end
      end
      VALID: begin
        if (hit_ack) begin
          if (hit_count != '1) hit_count_n = hit_count + 1'b1;
          if (pending) begin
            hit_x_n = cap_x;
            hit_y_n = cap_y;
          end else begin
            rpt_state_n = IDLE;
          end
        end else if (pending) begin
`ifdef COLLISION_OVERRUN_EN
          overrun_n = 1'b1;
`endif
        end
      end
      default: rpt_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: directed vector table, corner-case
// sequences and randomized traffic against a frame-level reference model.
module tb_collision_detector;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       is_alien = 1'b0;
  logic       is_missile = 1'b0;
  logic       hit_ack = 1'b0;
  logic       hit_valid;
  logic [9:0] hit_x;
  logic [9:0] hit_y;
  logic [7:0] hit_count;
`ifdef COLLISION_OVERRUN_EN
  logic       overrun;
`endif

  collision_detector #(.SCREEN_W(10'd640), .SCREEN_H(10'd480), .COUNT_W(8)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .is_alien   (is_alien),
    .is_missile (is_missile),
    .hit_ack    (hit_ack),
    .hit_valid  (hit_valid),
    .hit_x      (hit_x),
    .hit_y      (hit_y),
    .hit_count  (hit_count)
`ifdef COLLISION_OVERRUN_EN
    ,
    .overrun    (overrun)
`endif
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the first on-screen hit per frame and the pending
  // report, advancing once per clock from the same inputs the DUT samples.
  bit model_on = 0;
  bit m_fc_prev, m_fe, m_fhit, m_valid, m_ovr;
  int m_fx, m_fy, m_x, m_y, m_count;

  task automatic model_reset();
    m_fc_prev = 0; m_fe = 0; m_fhit = 0; m_valid = 0; m_ovr = 0;
    m_fx = 0; m_fy = 0; m_x = 0; m_y = 0; m_count = 0;
  endtask

  task automatic model_step();
    bit hit_now, fe, rep;
    int rx, ry;
    hit_now = is_alien && is_missile && (int'(DrawX) < 640) && (int'(DrawY) < 480);
    fe = m_fe;
    m_fe = frame_clk && !m_fc_prev;
    m_fc_prev = frame_clk;
    rep = 0; rx = 0; ry = 0;
    if (fe) begin
      rep = m_fhit; rx = m_fx; ry = m_fy;
      m_fhit = hit_now;
      if (hit_now) begin m_fx = int'(DrawX); m_fy = int'(DrawY); end
    end else if (!m_fhit && hit_now) begin
      m_fhit = 1; m_fx = int'(DrawX); m_fy = int'(DrawY);
    end
    if (m_valid && hit_ack) begin
      if (m_count < 255) m_count++;
      m_valid = 0;
    end
    if (rep) begin
      if (!m_valid) begin m_valid = 1; m_x = rx; m_y = ry; end
      else m_ovr = 1;
    end
  endtask

  task automatic step(input logic fc, input int x, input int y,
                      input logic a, input logic m, input logic ack);
    logic [31:0] xv, yv;
    xv = x; yv = y;
    frame_clk = fc; DrawX = xv[9:0]; DrawY = yv[9:0];
    is_alien = a; is_missile = m; hit_ack = ack;
    @(posedge Clk);
    if (model_on) model_step();
    @(negedge Clk);
  endtask

  task automatic check_out(input string tag, input int v, input int x, input int y, input int c);
    check({tag, ".valid"}, int'(hit_valid), v);
    check({tag, ".x"}, int'(hit_x), x);
    check({tag, ".y"}, int'(hit_y), y);
    check({tag, ".count"}, int'(hit_count), c);
  endtask

  typedef struct {
    logic fc; int x; int y; logic a; logic m; logic ack;
    int ev; int ex; int ey; int ec;
  } vec_t;

  vec_t tbl[10];
  logic rfc;

  initial begin
    tbl[0] = '{1'b0, 100,  50, 1'b1, 1'b1, 1'b0, 0,   0,  0, 0};
    tbl[1] = '{1'b0, 200,  60, 1'b1, 1'b1, 1'b0, 0,   0,  0, 0};
    tbl[2] = '{1'b1,   0,   0, 1'b0, 1'b0, 1'b0, 0,   0,  0, 0};
    tbl[3] = '{1'b1,   0,   0, 1'b0, 1'b0, 1'b0, 1, 100, 50, 0};
    tbl[4] = '{1'b0,   0,   0, 1'b0, 1'b0, 1'b1, 0, 100, 50, 1};
    tbl[5] = '{1'b0,   0,   0, 1'b0, 1'b0, 1'b1, 0, 100, 50, 1};
    tbl[6] = '{1'b0, 700,  10, 1'b1, 1'b1, 1'b0, 0, 100, 50, 1};
    tbl[7] = '{1'b1,   0,   0, 1'b0, 1'b0, 1'b0, 0, 100, 50, 1};
    tbl[8] = '{1'b1,   0,   0, 1'b0, 1'b0, 1'b0, 0, 100, 50, 1};
    tbl[9] = '{1'b0,   0,   0, 1'b0, 1'b0, 1'b0, 0, 100, 50, 1};

    repeat (2) @(negedge Clk);
    check_out("reset", 0, 0, 0, 0);
`ifdef COLLISION_OVERRUN_EN
    check("reset.overrun", int'(overrun), 0);
`endif
    Reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].fc, tbl[i].x, tbl[i].y, tbl[i].a, tbl[i].m, tbl[i].ack);
      check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ex, tbl[i].ey, tbl[i].ec);
    end

    // Unacked report followed by a second captured frame: new hit dropped.
    step(0, 5, 6, 1, 1, 0); step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
    check_out("rpt2", 1, 5, 6, 1);
    step(0, 300, 300, 1, 1, 0); step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
    check_out("overrun", 1, 5, 6, 1);
`ifdef COLLISION_OVERRUN_EN
    check("overrun.flag", int'(overrun), 1);
`endif

    // Ack coincides with the frame edge carrying a pending hit.
    step(0, 10, 20, 1, 1, 0); step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 1);
    check_out("ack_edge", 1, 10, 20, 2);
    step(0, 0, 0, 0, 0, 1);
    check_out("ack3", 0, 10, 20, 3);

    for (int i = 0; i < 300; i++) begin
      step(0, i + 1, i + 2, 1, 1, 0); step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
    end
    check_out("sat", 0, 300, 301, 255);
    step(0, 1, 2, 1, 1, 0); step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check_out("sat_hold", 0, 1, 2, 255);

    // Async reset in the middle of a handshake, away from any clock edge.
    step(0, 7, 8, 1, 1, 0); step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
    check_out("pre_rst", 1, 7, 8, 255);
    #2 Reset_n = 1'b0;
    #1 check_out("async_rst", 0, 0, 0, 0);
`ifdef COLLISION_OVERRUN_EN
    check("async_rst.overrun", int'(overrun), 0);
`endif
    @(negedge Clk);
    frame_clk = 0; is_alien = 0; is_missile = 0; hit_ack = 0;
    @(negedge Clk);
    Reset_n = 1'b1;

    model_reset();
    model_on = 1;
    rfc = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) rfc = ~rfc;
      step(rfc, int'($urandom_range(0, 767)), int'($urandom_range(0, 599)),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 2) == 0));
      check("rnd.valid", int'(hit_valid), int'(m_valid));
      check("rnd.x", int'(hit_x), m_x);
      check("rnd.y", int'(hit_y), m_y);
      check("rnd.count", int'(hit_count), m_count);
`ifdef COLLISION_OVERRUN_EN
      check("rnd.overrun", int'(overrun), int'(m_ovr));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
